// File: rtl/dc_ipu_addr_compute_s2.sv
// IPU address-compute stage 2: restoring divide of tex_size*(2x+1) by 2*img_size,
// producing an integer part plus FRAC_WIDTH fractional bits, one quotient bit per cycle.
module dc_ipu_addr_compute_s2 #(
    parameter int IMG_SIZE_WIDTH = 12,
    parameter int RESULT_WIDTH   = 24,
    parameter int FRAC_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IMG_SIZE_WIDTH-1:0] in_img_size,
    input  logic [RESULT_WIDTH-1:0]   in_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RESULT_WIDTH-1:0]   out_int,
    output logic [FRAC_WIDTH-1:0]     out_frac,
    output logic                      out_div_zero
);

    localparam int N     = RESULT_WIDTH + FRAC_WIDTH;
    localparam int CNT_W = $clog2(N);
    localparam int REM_W = IMG_SIZE_WIDTH + 2;
    localparam int DIV_W = IMG_SIZE_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nx;
    logic [CNT_W-1:0]          r_cnt;
    logic [N-1:0]              r_dividend;
    logic [DIV_W-1:0]          r_divisor;
    logic [REM_W-1:0]          r_rem;
    logic [N-1:0]              r_quot;
    logic                      r_div_zero;
    logic [RESULT_WIDTH-1:0]   r_out_int;
    logic [FRAC_WIDTH-1:0]     r_out_frac;

    logic                      w_accept;
    logic                      w_last;
    logic [REM_W-1:0]          w_rem_sh;
    logic                      w_ge;
    logic [REM_W-1:0]          w_rem_nx;
    logic [N-1:0]              w_quot_nx;

    assign w_accept = in_valid && in_ready && !clr;
    assign w_last   = (r_state == DIV) && (r_cnt == '0);

    // One restoring step: remainder stays below the divisor, so REM_W bits never overflow
    assign w_rem_sh  = {r_rem[REM_W-2:0], r_dividend[N-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_divisor});
    assign w_rem_nx  = w_ge ? (w_rem_sh - {1'b0, r_divisor}) : w_rem_sh;
    assign w_quot_nx = {r_quot[N-2:0], w_ge};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_nx = DIV;
            DIV:  if (r_cnt == '0) w_state_nx = DONE;
            DONE: if (out_ready) w_state_nx = in_valid ? DIV : IDLE;
            default: w_state_nx = IDLE;
        endcase
        if (clr) w_state_nx = IDLE;
    end

    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_div_zero = 1'b0;
        case (r_state)
            IDLE: in_ready = 1'b1;
            DONE: begin
                in_ready     = out_ready;
                out_valid    = 1'b1;
                out_div_zero = r_div_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_div_zero <= 1'b0;
            r_out_int  <= '0;
            r_out_frac <= '0;
        end else if (clr) begin
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= CNT_W'(N - 1);
            r_dividend <= {in_result, {FRAC_WIDTH{1'b0}}};
            r_divisor  <= {in_img_size, 1'b0};
            r_rem      <= '0;
            r_quot     <= '0;
            r_div_zero <= (in_img_size == '0);
        end else if (r_state == DIV) begin
            r_dividend <= {r_dividend[N-2:0], 1'b0};
            r_rem      <= w_rem_nx;
            r_quot     <= w_quot_nx;
            if (w_last) begin
                r_out_int  <= w_quot_nx[N-1:FRAC_WIDTH];
                r_out_frac <= w_quot_nx[FRAC_WIDTH-1:0];
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign out_int  = r_out_int;
    assign out_frac = r_out_frac;

endmodule

// File: tb/tb_dc_ipu_addr_compute_s2.sv
// Directed bench for dc_ipu_addr_compute_s2: latency, results, backpressure,
// handoff, clear and asynchronous reset behaviour.
module tb_dc_ipu_addr_compute_s2;

    logic        clk = 1'b0;
    logic        nreset;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_img_size;
    logic [23:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_int;
    logic [7:0]  out_frac;
    logic        out_div_zero;

    int checks = 0;
    int errors = 0;

    dc_ipu_addr_compute_s2 dut (
        .clk          (clk),
        .nreset       (nreset),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_img_size  (in_img_size),
        .in_result    (in_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_int      (out_int),
        .out_frac     (out_frac),
        .out_div_zero (out_div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for out_valid after the accepting edge; returns edges counted
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic accept(input logic [23:0] res, input logic [11:0] img);
        in_result   = res;
        in_img_size = img;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [23:0] res, input logic [11:0] img,
                          input logic [23:0] e_int, input logic [7:0] e_frac, input logic e_dz);
        int n;
        accept(res, img);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_valid(n);
        chk({tag, "_lat"}, 32'(n), 32'd32);
        chk({tag, "_int"}, 32'(out_int), 32'(e_int));
        chk({tag, "_frac"}, 32'(out_frac), 32'(e_frac));
        chk({tag, "_dz"}, 32'(out_div_zero), 32'(e_dz));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vld"}, 32'(out_valid), 32'd0);
        chk({tag, "_int"}, 32'(out_int), 32'd0);
        chk({tag, "_frac"}, 32'(out_frac), 32'd0);
        chk({tag, "_dz"}, 32'(out_div_zero), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        int pulses;
        nreset      = 1'b0;
        clr         = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_result   = '0;
        in_img_size = '0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        nreset = 1'b1;
        tick();

        // 28*256/16 = 448 = 0x1C0
        run_op("nominal", 24'd28, 12'd8, 24'd1, 8'hC0, 1'b0);
        run_op("zero", 24'd0, 12'd5, 24'd0, 8'h00, 1'b0);
        run_op("exact", 24'd48, 12'd3, 24'd8, 8'h00, 1'b0);
        run_op("divzero", 24'd100, 12'd0, 24'hFFFFFF, 8'hFF, 1'b1);
        // 1000/(2*7) = 71.428..., frac = floor(0.428571*256) = 109 = 0x6D
        run_op("frac", 24'd1000, 12'd7, 24'd71, 8'h6D, 1'b0);

        // Backpressure: hold DONE, offered input must not be taken
        accept(24'd28, 12'd8);
        wait_valid(n);
        chk("bp_lat", 32'(n), 32'd32);
        in_result   = 24'd48;
        in_img_size = 12'd3;
        in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_vld", 32'(out_valid), 32'd1);
            chk("bp_rdy", 32'(in_ready), 32'd0);
            chk("bp_int", 32'(out_int), 32'd1);
            chk("bp_frac", 32'(out_frac), 32'hC0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("handoff_vld", 32'(out_valid), 32'd0);
        chk("handoff_busy", 32'(in_ready), 32'd0);
        wait_valid(n);
        chk("handoff_lat", 32'(n), 32'd32);
        chk("handoff_int", 32'(out_int), 32'd8);
        chk("handoff_frac", 32'(out_frac), 32'h00);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Clear mid-divide, with a competing in_valid on the clear edge
        accept(24'd48, 12'd3);
        repeat (10) tick();
        clr         = 1'b1;
        in_valid    = 1'b1;
        in_result   = 24'd28;
        in_img_size = 12'd8;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_rdy", 32'(in_ready), 32'd1);
        chk("clr_vld", 32'(out_valid), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("clr_no_pulse", 32'(pulses), 32'd0);
        run_op("after_clr", 24'd28, 12'd8, 24'd1, 8'hC0, 1'b0);

        // Async reset mid-divide
        accept(24'd48, 12'd3);
        repeat (5) tick();
        #2 nreset = 1'b0;
        #1 chk_reset_outputs("rst_div");
        tick();
        nreset = 1'b1;
        tick();

        // Async reset in DONE
        accept(24'd28, 12'd8);
        wait_valid(n);
        chk("rst_done_pre_vld", 32'(out_valid), 32'd1);
        chk("rst_done_pre_int", 32'(out_int), 32'd1);
        #2 nreset = 1'b0;
        #1 chk_reset_outputs("rst_done");
        tick();
        nreset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
